decimal_to_hex: RTL and testbench
=================================

DECIMAL_TO_HEX -- requirements
Module: decimal_to_hex

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of packed BCD input digits.
REQ-002 The block SHALL have derived localparam BIN_W, default 14, equal to the minimum width holding 10^DIGITS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the source presents a BCD word.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port bcd, input, 4*DIGITS bits: packed BCD, most significant digit in the top nibble.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is held stable.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the sink accepts the result.
REQ-010 The block SHALL have port binary, output, BIN_W bits: the unsigned binary value.
REQ-011 The block SHALL have port error, output, 1 bit: at least one input nibble was greater than 9.

Function
REQ-012 The block SHALL use three states: IDLE, CONV and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, when in_valid&&in_ready, the block SHALL capture bcd into a shift register, clear the accumulator, digit counter and error latch, and enter CONV.
REQ-015 In CONV, each cycle the block SHALL compute acc <= acc*10 + top nibble, shift the register left by 4, increment the counter, and OR (nibble>9) into the error latch.
REQ-016 After DIGITS CONV cycles the block SHALL enter DONE.
REQ-017 out_valid SHALL rise exactly DIGITS clock edges after the accepting edge, giving latency 4 for the default.
REQ-018 The accumulator SHALL be BIN_W+1 bits wide so that invalid nibbles (worst case 15 per digit) cannot wrap it.
REQ-019 In DONE, binary SHALL equal acc[BIN_W-1:0] if error==0 and SHALL be 0 if error==1.
REQ-020 binary and error SHALL hold stable while out_valid=1 and out_ready=0; there is no timeout.
REQ-021 In DONE with out_ready=1, the block SHALL return to IDLE on the next edge; in_ready SHALL stay 0 during that cycle (no same-cycle bypass).
REQ-022 in_valid SHALL be ignored outside IDLE; bcd changes during CONV SHALL NOT affect the result.
REQ-023 When out_valid=0, binary and error SHALL be driven 0.

Reset
REQ-024 On rst=1, the block SHALL asynchronously enter IDLE and clear the accumulator, shift register, counter and error latch.
REQ-025 During reset, outputs SHALL be in_ready=1, out_valid=0, binary=0 and error=0.
REQ-026 Reset asserted mid-CONV or mid-DONE SHALL abort the conversion with no partial result emitted; the first accept after release SHALL start a fresh conversion.

Structure
REQ-027 The state enum (IDLE/CONV/DONE) and the BCD_MAX_DIGIT=9 constant SHALL live in a shared package, bcd_pkg.
REQ-028 The multiply-accumulate step (acc*10+digit, implemented as shift-add (acc<<3)+(acc<<1)+digit, plus the invalid-digit flag) SHALL be a combinational sub-module, bcd_digit_mac.
REQ-029 No divider or multiplier primitive SHALL be inferred.

Verification
REQ-030 Scenario: bcd=16'h1234 accepted, out_ready=1 -> out_valid after 4 edges, binary=1234 (0x4D2), error=0, then in_ready=1 on the next cycle.
REQ-031 Scenario: bcd=16'h9999 -> binary=9999 (0x270F), error=0; bcd=16'h0000 -> binary=0, error=0.
REQ-032 Scenario: bcd=16'h12A4 -> error=1 and binary=0; a following bcd=16'h0042 -> error=0, binary=42, confirming the error latch is cleared.
REQ-033 Scenario: out_ready held 0 for 10 cycles in DONE with bcd=16'h0500 -> binary=500 held stable; in_valid pulses during this time are ignored and in_ready stays 0.
REQ-034 Scenario: rst pulsed on the 2nd CONV cycle of 16'h8765 -> immediately out_valid=0, in_ready=1; the next accept of 16'h0007 -> binary=7.
REQ-035 Scenario: back-to-back words 16'h0001 and 16'h0010 with in_valid held high and out_ready=1 -> results 1 and 10, one conversion every 6 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal step: acc*10 + digit using shifts and adds only, plus an invalid-digit flag.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int W = 15
) (
  input  logic [W-1:0] acc_i,
  input  logic [3:0]   digit_i,
  output logic [W-1:0] acc_o,
  output logic         bad_o
);

  assign acc_o = (acc_i << 3) + (acc_i << 1) + W'(digit_i);
  assign bad_o = (digit_i > 4'(BCD_MAX_DIGIT));

endmodule

// File: rtl/decimal_to_hex.sv
// Serial packed-BCD to binary converter: one digit per clock, result held until the sink takes it.
module decimal_to_hex
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int BIN_W  = $clog2(10 ** DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary,
  output logic                  error
);

  localparam int ACC_W = BIN_W + 1;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [4*DIGITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [ACC_W-1:0]    mac_acc;
  logic                mac_bad;

  bcd_digit_mac #(.W(ACC_W)) u_mac (
    .acc_i   (acc_q),
    .digit_i (sr_q[4*DIGITS-1 -: 4]),
    .acc_o   (mac_acc),
    .bad_o   (mac_bad)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = bcd;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = mac_acc;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + CNT_W'(1);
        err_d = err_q | mac_bad;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from flops; result and flag read as zero outside DONE.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign binary    = (out_valid && !err_q) ? acc_q[BIN_W-1:0] : '0;
  assign error     = out_valid && err_q;

endmodule

// File: tb/tb_decimal_to_hex.sv
// Directed, table-driven bench for decimal_to_hex with hand-computed expected values.
module tb_decimal_to_hex;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] binary;
  logic        error;

  int checks = 0;
  int errors = 0;

  decimal_to_hex #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary    (binary),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [13:0] exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Accept one word, scramble bcd during CONV, check latency, result and return to IDLE.
  task automatic convert(input logic [15:0] w, input logic [13:0] eb, input logic ee);
    int lat;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    bcd       = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd      = 16'hFFFF;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("binary", 32'(binary), 32'(eb));
    chk("error", 32'(error), 32'(ee));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_binary_zero", 32'(binary), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;

    vecs[0]  = '{16'h1234, 14'd1234, 1'b0};
    vecs[1]  = '{16'h9999, 14'd9999, 1'b0};
    vecs[2]  = '{16'h0000, 14'd0,    1'b0};
    vecs[3]  = '{16'h12A4, 14'd0,    1'b1};
    vecs[4]  = '{16'h0042, 14'd42,   1'b0};
    vecs[5]  = '{16'h0009, 14'd9,    1'b0};
    vecs[6]  = '{16'h000A, 14'd0,    1'b1};
    vecs[7]  = '{16'h9000, 14'd9000, 1'b0};
    vecs[8]  = '{16'hF000, 14'd0,    1'b1};
    vecs[9]  = '{16'h0807, 14'd807,  1'b0};
    vecs[10] = '{16'h5060, 14'd5060, 1'b0};
    vecs[11] = '{16'hFFFF, 14'd0,    1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd       = 16'h0000;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_binary", 32'(binary), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].word, vecs[i].exp_bin, vecs[i].exp_err);
    end

    // Sink stalls for 10 cycles; result must hold and in_valid pulses be ignored.
    @(negedge clk);
    bcd       = 16'h0500;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_latency", 32'(n), 32'd4);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      bcd      = 16'h1111;
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_binary", 32'(binary), 32'd500);
      chk("hold_error", 32'(error), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second CONV cycle aborts with no partial result.
    @(negedge clk);
    bcd      = 16'h8765;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_binary", 32'(binary), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    convert(16'h0007, 14'd7, 1'b0);

    // Back-to-back words with in_valid held high: one conversion every 6 cycles.
    @(negedge clk);
    bcd       = 16'h0001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    bcd = 16'h0010;
    n   = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'd4);
    chk("b2b_first_binary", 32'(binary), 32'd1);
    @(posedge clk);
    #1;
    n++;
    chk("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_second_at", 32'(n), 32'd10);
    chk("b2b_second_binary", 32'(binary), 32'd10);
    chk("b2b_second_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_end_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
